tran_pack: RTL and testbench

TRAN_PACK -- requirements
Module: tran_pack

---
 rtl/tran_pack.sv | 122 ++++++++++++
 tb/tb_tran_pack.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tran_pack.sv
// tran_pack: packs variable-count beats of UNIT_W-bit units into words of
// OUT_UNITS units, oldest unit in the MSBs, through a 2*OUT_UNITS-unit
// accumulator.
// Ports: Clk, Rst (async active-low), start/cnt/DB/in_rdy (input beat),
//        Out_en/Out/out_rdy (registered output word), err (sticky illegal cnt),
//        flush (only with TRAN_PACK_FLUSH_EN: emit a zero-padded residual word).
module tran_pack #(
    parameter int UNIT_W    = 4,
    parameter int IN_UNITS  = 2,
    parameter int OUT_UNITS = 2
) (
    input  logic                          Clk,
    input  logic                          Rst,
`ifdef TRAN_PACK_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic                          start,
    input  logic [$clog2(IN_UNITS+1)-1:0] cnt,
    input  logic [IN_UNITS*UNIT_W-1:0]    DB,
    output logic                          in_rdy,
    input  logic                          out_rdy,
    output logic                          Out_en,
    output logic [OUT_UNITS*UNIT_W-1:0]   Out,
    output logic                          err
);
    localparam int CAP = 2 * OUT_UNITS;
    localparam int FW  = $clog2(CAP + 1);
    localparam int CW  = $clog2(IN_UNITS + 1);

    logic [UNIT_W-1:0]           acc_q [CAP];
    logic [UNIT_W-1:0]           acc_d [CAP];
    logic [UNIT_W-1:0]           comb  [CAP];
    logic [FW-1:0]               fill_q, fill_d;
    logic [FW-1:0]               n_new, avail;
    logic [OUT_UNITS*UNIT_W-1:0] out_q, out_d, word;
    logic                        en_q, en_d, err_q, err_d;
    logic                        room, legal, take, push, free, load;

    // Readiness depends only on registered fill (plus flush, which refuses beats).
    assign room = (fill_q <= FW'(CAP - IN_UNITS));
`ifdef TRAN_PACK_FLUSH_EN
    assign in_rdy = room && !flush;
`else
    assign in_rdy = room;
`endif

    assign Out_en = en_q;
    assign Out    = out_q;
    assign err    = err_q;

    always_comb begin
        legal = (cnt != '0) && (cnt <= CW'(IN_UNITS));
        take  = start && in_rdy;
        push  = take && legal;
        n_new = push ? FW'(cnt) : '0;
        avail = fill_q + n_new;
        free  = !en_q || out_rdy;
        load  = free && (avail >= FW'(OUT_UNITS));

        // Existing units followed by the incoming ones; slots past fill are
        // always zero, so the new units simply overwrite from fill upward.
        for (int i = 0; i < CAP; i++) begin
            comb[i] = acc_q[i];
            for (int j = 0; j < IN_UNITS; j++) begin
                if (push && (CW'(j) < cnt) && (FW'(i) == fill_q + FW'(j)))
                    comb[i] = DB[(IN_UNITS-1-j)*UNIT_W +: UNIT_W];
            end
        end

        // Oldest units into the MSBs; missing units read as zero.
        for (int k = 0; k < OUT_UNITS; k++) begin
            word[(OUT_UNITS-1-k)*UNIT_W +: UNIT_W] =
                (FW'(k) < avail) ? comb[k] : '0;
        end

        acc_d  = comb;
        fill_d = avail;
        out_d  = out_q;
        en_d   = en_q;
        err_d  = err_q | (take && !legal);

        if (load) begin
            out_d  = word;
            en_d   = 1'b1;
            fill_d = avail - FW'(OUT_UNITS);
            for (int i = 0; i < CAP - OUT_UNITS; i++)
                acc_d[i] = comb[i + OUT_UNITS];
            for (int i = CAP - OUT_UNITS; i < CAP; i++)
                acc_d[i] = '0;
        end else if (en_q && out_rdy) begin
            en_d = 1'b0;
        end

`ifdef TRAN_PACK_FLUSH_EN
        // No beat is taken while flush is high, so avail equals fill here.
        if (!load && flush && free && (fill_q != '0)) begin
            out_d  = word;
            en_d   = 1'b1;
            fill_d = '0;
            for (int i = 0; i < CAP; i++)
                acc_d[i] = '0;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < CAP; i++)
                acc_q[i] <= '0;
            fill_q <= '0;
            out_q  <= '0;
            en_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            out_q  <= out_d;
            en_q   <= en_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_tran_pack.sv
// tb_tran_pack: directed scenarios plus a randomized run for tran_pack,
// checked against a unit-queue reference model.
module tb_tran_pack;
    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] cnt = 2'd0;
    logic [7:0] DB = 8'h00;
    logic       out_rdy = 1'b1;
    logic       flush = 1'b0;
    logic       in_rdy;
    logic       Out_en;
    logic [7:0] Out;
    logic       err;

    int checks = 0;
    int failures = 0;

    logic [3:0] q[$];
    logic [7:0] m_out = 8'h00;
    logic       m_en = 1'b0;
    logic       m_err = 1'b0;
    logic       rdy_seen, rdy_exp;

    tran_pack #(.UNIT_W(4), .IN_UNITS(2), .OUT_UNITS(2)) dut (
        .Clk(Clk),
        .Rst(Rst),
`ifdef TRAN_PACK_FLUSH_EN
        .flush(flush),
`endif
        .start(start),
        .cnt(cnt),
        .DB(DB),
        .in_rdy(in_rdy),
        .out_rdy(out_rdy),
        .Out_en(Out_en),
        .Out(Out),
        .err(err)
    );

    always #5 Clk = ~Clk;

    function automatic void model_reset();
        q.delete();
        m_out = 8'h00;
        m_en = 1'b0;
        m_err = 1'b0;
    endfunction

    // One clock cycle: drive inputs, capture in_rdy, advance the model.
    task automatic step(input logic s, input logic [1:0] c,
                        input logic [7:0] d, input logic r, input logic f);
        logic acc, fr;
        start = s; cnt = c; DB = d; out_rdy = r; flush = f;
        #1;
        rdy_exp = (q.size() <= 2) && !f;
        rdy_seen = in_rdy;
        @(posedge Clk);
        acc = s && rdy_exp;
        fr = !m_en || r;
        if (acc && c >= 2'd1 && c <= 2'd2) begin
            for (int j = 0; j < int'(c); j++)
                q.push_back(d[7-4*j -: 4]);
        end else if (acc) begin
            m_err = 1'b1;
        end
        if (fr && q.size() >= 2) begin
            m_out = {q[0], q[1]};
            void'(q.pop_front());
            void'(q.pop_front());
            m_en = 1'b1;
        end else if (fr && f && q.size() == 1) begin
            m_out = {q[0], 4'h0};
            q.delete();
            m_en = 1'b1;
        end else if (m_en && r) begin
            m_en = 1'b0;
        end
        #1;
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        #3;
        checks++;
        if (Out_en !== 1'b0 || Out !== 8'h00 || err !== 1'b0 || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset: en=%b out=%h err=%b rdy=%b want 0 00 0 1",
                     Out_en, Out, err, in_rdy);
        end
        @(negedge Clk) Rst = 1'b1;
        model_reset();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_single();
        step(1, 2, 8'hA5, 1, 0);
        checks++;
        if (Out_en !== 1'b1 || Out !== 8'hA5) begin
            failures++;
            $display("FAIL single: en=%b out=%h want 1 a5", Out_en, Out);
        end
        step(0, 0, 8'h00, 1, 0);
        checks++;
        if (Out_en !== 1'b0 || Out !== 8'hA5) begin
            failures++;
            $display("FAIL single_drop: en=%b out=%h want 0 a5", Out_en, Out);
        end
    endtask

    task automatic test_pair();
        step(1, 1, 8'h3F, 1, 0);
        checks++;
        if (Out_en !== 1'b0) begin
            failures++;
            $display("FAIL pair_first: en=%b want 0", Out_en);
        end
        step(1, 1, 8'hC0, 1, 0);
        checks++;
        if (Out_en !== 1'b1 || Out !== 8'h3C) begin
            failures++;
            $display("FAIL pair: en=%b out=%h want 1 3c", Out_en, Out);
        end
        step(0, 0, 8'h00, 1, 0);
    endtask

    task automatic test_three();
        logic [7:0] want [3];
        logic [1:0] cn [3];
        logic [7:0] db [3];
        logic       wen [3];
        want = '{8'h00, 8'h79, 8'hE1};
        wen  = '{1'b0, 1'b1, 1'b1};
        cn   = '{2'd1, 2'd2, 2'd1};
        db   = '{8'h70, 8'h9E, 8'h10};
        for (int i = 0; i < 3; i++) begin
            step(1, cn[i], db[i], 1, 0);
            checks++;
            if (rdy_seen !== 1'b1 || Out_en !== wen[i] || (wen[i] && Out !== want[i])) begin
                failures++;
                $display("FAIL three[%0d]: rdy=%b en=%b out=%h want 1 %b %h",
                         i, rdy_seen, Out_en, Out, wen[i], want[i]);
            end
        end
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
        checks++;
        if (Out_en !== 1'b0 || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL three_empty: en=%b rdy=%b want 0 1", Out_en, in_rdy);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] v [4];
        logic       wr [4];
        v  = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step(1, 2, v[i], 0, 0);
            checks++;
            if (rdy_seen !== wr[i] || Out_en !== 1'b1 || Out !== 8'h11) begin
                failures++;
                $display("FAIL bp[%0d]: rdy=%b en=%b out=%h want %b 1 11",
                         i, rdy_seen, Out_en, Out, wr[i]);
            end
        end
        step(1, 2, 8'h44, 1, 0);
        checks++;
        if (rdy_seen !== 1'b0 || Out_en !== 1'b1 || Out !== 8'h22) begin
            failures++;
            $display("FAIL bp_release: rdy=%b en=%b out=%h want 0 1 22",
                     rdy_seen, Out_en, Out);
        end
        step(1, 2, 8'h44, 1, 0);
        checks++;
        if (rdy_seen !== 1'b1 || Out_en !== 1'b1 || Out !== 8'h33) begin
            failures++;
            $display("FAIL bp_next: rdy=%b en=%b out=%h want 1 1 33",
                     rdy_seen, Out_en, Out);
        end
        step(0, 0, 8'h00, 1, 0);
        checks++;
        if (Out_en !== 1'b1 || Out !== 8'h44) begin
            failures++;
            $display("FAIL bp_last: en=%b out=%h want 1 44", Out_en, Out);
        end
        step(0, 0, 8'h00, 1, 0);
    endtask

    task automatic test_error();
        step(1, 1, 8'h50, 1, 0);
        step(1, 3, 8'hFF, 1, 0);
        checks++;
        if (err !== 1'b1 || Out_en !== 1'b0) begin
            failures++;
            $display("FAIL err_cnt3: err=%b en=%b want 1 0", err, Out_en);
        end
        step(1, 0, 8'hEE, 1, 0);
        step(1, 1, 8'hA0, 1, 0);
        checks++;
        if (err !== 1'b1 || Out_en !== 1'b1 || Out !== 8'h5A) begin
            failures++;
            $display("FAIL err_keep: err=%b en=%b out=%h want 1 1 5a", err, Out_en, Out);
        end
        step(0, 0, 8'h00, 1, 0);
    endtask

`ifdef TRAN_PACK_FLUSH_EN
    task automatic test_flush();
        step(1, 1, 8'h60, 1, 0);
        step(1, 2, 8'h77, 1, 1);
        checks++;
        if (rdy_seen !== 1'b0 || Out_en !== 1'b1 || Out !== 8'h60) begin
            failures++;
            $display("FAIL flush: rdy=%b en=%b out=%h want 0 1 60", rdy_seen, Out_en, Out);
        end
        step(0, 0, 8'h00, 1, 1);
        checks++;
        if (Out_en !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty: en=%b want 0", Out_en);
        end
        step(1, 2, 8'h12, 1, 0);
        checks++;
        if (Out_en !== 1'b1 || Out !== 8'h12) begin
            failures++;
            $display("FAIL flush_after: en=%b out=%h want 1 12", Out_en, Out);
        end
        step(0, 0, 8'h00, 1, 0);
    endtask
`endif

    task automatic test_reset_mid();
        step(1, 2, 8'hA5, 1, 0);
        step(1, 1, 8'h70, 0, 0);
        #2 Rst = 1'b0;
        #2;
        checks++;
        if (Out_en !== 1'b0 || Out !== 8'h00 || err !== 1'b0 || in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: en=%b out=%h err=%b rdy=%b want 0 00 0 1",
                     Out_en, Out, err, in_rdy);
        end
        Rst = 1'b1;
        model_reset();
        #1;
        step(1, 2, 8'hB4, 1, 0);
        checks++;
        if (Out_en !== 1'b1 || Out !== 8'hB4) begin
            failures++;
            $display("FAIL reset_resume: en=%b out=%h want 1 b4", Out_en, Out);
        end
        step(0, 0, 8'h00, 1, 0);
    endtask

    task automatic test_random();
        logic       s, r, f;
        logic [1:0] c;
        logic [7:0] d;
        for (int n = 0; n < 500; n++) begin
            s = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3))
                                             : 2'($urandom_range(1, 2));
            d = 8'($urandom);
            r = ($urandom_range(0, 2) != 0);
`ifdef TRAN_PACK_FLUSH_EN
            f = ($urandom_range(0, 9) == 0);
`else
            f = 1'b0;
`endif
            step(s, c, d, r, f);
            checks++;
            if (rdy_seen !== rdy_exp || Out_en !== m_en || err !== m_err ||
                (m_en && Out !== m_out)) begin
                failures++;
                $display("FAIL random[%0d]: rdy=%b en=%b out=%h err=%b want %b %b %h %b",
                         n, rdy_seen, Out_en, Out, err, rdy_exp, m_en, m_out, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_three();
        test_back_pressure();
        test_error();
`ifdef TRAN_PACK_FLUSH_EN
        test_flush();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
